alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The module SHALL have parameter W, default 16, giving the data width of all operand and result ports.
REQ-002 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 The module SHALL have port cmd_valid, input, 1 bit, command request.
REQ-005 The module SHALL have port cmd_ready, output, 1 bit, command accept.
REQ-006 The module SHALL have port cmd_op, input, 3 bits: values 0-6 are ALU opcodes; 7 is macro-op SUB (A-B).
REQ-007 The module SHALL have ports cmd_a and cmd_b, input, W bits each, the operands.
REQ-008 The module SHALL have port cmd_cin, input, 1 bit, carry-in for opcode 010.
REQ-009 The module SHALL have ports alu_opc, output, 3 bits; alu_a and alu_b, output, W bits each; alu_c, output, 1 bit. These drive the external combinational ALU.
REQ-010 The module SHALL have port alu_w, input, W bits, the ALU result.
REQ-011 The module SHALL have ports alu_zer and alu_neg, input, 1 bit each, the ALU flags.
REQ-012 The module SHALL have port rsp_valid, output, 1 bit, result available.
REQ-013 The module SHALL have port rsp_ready, input, 1 bit, result consumed.
REQ-014 The module SHALL have port rsp_w, output, W bits; and ports rsp_zer and rsp_neg, output, 1 bit each. These are the registered result and flags.

Function
REQ-015 States SHALL be IDLE, EXEC, NEG, ADD and RESP.
REQ-016 cmd_ready SHALL be 1 exactly when the state is IDLE.
REQ-017 A command SHALL be accepted on the clk edge where cmd_valid=1 and cmd_ready=1.
REQ-018 On acceptance, cmd_op, cmd_a, cmd_b and cmd_cin SHALL be registered.
REQ-019 On acceptance, the next state SHALL be EXEC for cmd_op 0-6 and NEG for cmd_op 7.
REQ-020 In EXEC, outputs SHALL be: alu_opc = registered op; alu_a = A; alu_b = B; alu_c = cin.
REQ-021 At the end of EXEC, alu_w, alu_zer and alu_neg SHALL be latched into rsp_w, rsp_zer and rsp_neg, and the next state SHALL be RESP.
REQ-022 In NEG, outputs SHALL be: alu_opc = 000; alu_a = B; alu_b = 0; alu_c = 0. At the end of NEG, alu_w SHALL be latched into internal register T, and the next state SHALL be ADD.
REQ-023 In ADD, outputs SHALL be: alu_opc = 010; alu_a = A; alu_b = T; alu_c = 0. At the end of ADD, the result and flags SHALL be latched, and the next state SHALL be RESP.
REQ-024 In IDLE and RESP, outputs SHALL be: alu_opc = 111; alu_a = 0; alu_b = 0; alu_c = 0.
REQ-025 rsp_valid SHALL be 1 exactly in RESP. rsp_w, rsp_zer and rsp_neg SHALL be held stable while rsp_valid=1 and rsp_ready=0.
REQ-026 In RESP with rsp_ready=1, the next state SHALL be IDLE. There SHALL be no same-cycle re-accept.
REQ-027 Latency, counted from the accept edge to the first rsp_valid=1 cycle, SHALL be 2 cycles for ops 0-6 and 3 cycles for SUB.
REQ-028 Minimum command spacing SHALL be 3 cycles for ops 0-6 and 4 cycles for SUB.
REQ-029 cmd_valid SHALL be ignored in every state other than IDLE. Command inputs may change freely after acceptance.
REQ-030 All arithmetic SHALL wrap modulo 2^W.
REQ-031 Flags SHALL be taken from the ALU only. SUB of equal operands SHALL give rsp_w = 0 and rsp_zer = 1.

Reset
REQ-032 While rst_n=0, the module SHALL hold: state IDLE; T, rsp_w, rsp_zer, rsp_neg, rsp_valid = 0; alu_opc = 111; alu_a, alu_b, alu_c = 0.
REQ-033 Assertion of rst_n=0 mid-operation SHALL take effect immediately, without waiting for clk, and SHALL abort the operation with no response generated.
REQ-034 No command SHALL be accepted on any edge where rst_n=0. The first accept SHALL be possible on the first rising edge after rst_n rises.

Verification
REQ-035 The bench SHALL apply op=010, A=0x0005, B=0x0003, cin=1, and check: alu_opc=010 in cycle 1; rsp_valid=1 in cycle 2; rsp_w=0x0009; zer=0; neg=0.
REQ-036 The bench SHALL apply op=7, A=0x0003, B=0x0005, and check: cycle 1 alu_opc=000 with alu_a=0x0005; cycle 2 alu_opc=010 with alu_b=0xFFFB; cycle 3 rsp_w=0xFFFE with neg=1.
REQ-037 The bench SHALL apply op=100, A=0x00F0, B=0x0F00, and check rsp_w=0x0000, zer=1, neg=0.
REQ-038 The bench SHALL hold rsp_ready=0 for 5 cycles with a second cmd_valid pending, and check: rsp outputs stable; cmd_ready=0; second command accepted only after rsp_ready=1 and return to IDLE.
REQ-039 The bench SHALL pulse rst_n=0 during the ADD state of a SUB, and check: rsp_valid never rises; outputs equal the REQ-032 values immediately; next command executes normally.
REQ-040 The bench SHALL drive cmd_valid=1 and rsp_ready=1 continuously with op=001, and check one accept every 3 cycles with rsp_w = A+1 each time.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: steps commands through an external combinational ALU.
// Opcodes 0-6 go to the ALU unchanged in a single EXEC cycle. Opcode 7
// (SUB, A-B) runs as two ALU passes: NEG computes -B into T, then ADD
// computes A+T. The result and flags are held until the consumer takes them.
module alu_sequencer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_cin,
  output logic [2:0]   alu_opc,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic         alu_c,
  input  logic [W-1:0] alu_w,
  input  logic         alu_zer,
  input  logic         alu_neg,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_w,
  output logic         rsp_zer,
  output logic         rsp_neg
);

  localparam logic [2:0] OPC_NEG = 3'b000;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_NOP = 3'b111;
  localparam logic [2:0] OP_SUB  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_NEG,
    S_ADD,
    S_RESP
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q, b_q, t_q;
  logic           cin_q;
  logic [W-1:0]   rsp_w_q;
  logic           rsp_zer_q, rsp_neg_q;
  logic           accept;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_w     = rsp_w_q;
  assign rsp_zer   = rsp_zer_q;
  assign rsp_neg   = rsp_neg_q;

  // State register; reset lands in IDLE immediately, abandoning any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      // NOTE: non-blocking assignments for all clocked state so every
      // register samples the pre-edge values regardless of block order.
      state_q <= state_d;
    end
  end

  // Next-state logic and ALU drive, both decoded from the current state.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    alu_opc = OPC_NOP;
    alu_a   = '0;
    alu_b   = '0;
    alu_c   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = (cmd_op == OP_SUB) ? S_NEG : S_EXEC;
      end
      S_EXEC: begin
        alu_opc = op_q;
        alu_a   = a_q;
        alu_b   = b_q;
        alu_c   = cin_q;
        state_d = S_RESP;
      end
      S_NEG: begin
        alu_opc = OPC_NEG;
        alu_a   = b_q;
        state_d = S_ADD;
      end
      S_ADD: begin
        alu_opc = OPC_ADD;
        alu_a   = a_q;
        alu_b   = t_q;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: capture the command on accept, -B in NEG, result in EXEC/ADD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the operand registers are reset too; they are few flops and
      // this keeps the ALU drive and response fully defined out of reset.
      op_q      <= OPC_NOP;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      t_q       <= '0;
      rsp_w_q   <= '0;
      rsp_zer_q <= 1'b0;
      rsp_neg_q <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= cmd_op;
        a_q   <= cmd_a;
        b_q   <= cmd_b;
        cin_q <= cmd_cin;
      end
      if (state_q == S_NEG) t_q <= alu_w;
      if (state_q == S_EXEC || state_q == S_ADD) begin
        rsp_w_q   <= alu_w;
        rsp_zer_q <= alu_zer;
        rsp_neg_q <= alu_neg;
      end
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed vectors, a behavioural model of the
// external ALU, and a scoreboard queue drained by an independent monitor.
module tb_alu_sequencer;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] w;
    logic         zer;
    logic         neg;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b;
  logic         cmd_cin;
  logic [2:0]   alu_opc;
  logic [W-1:0] alu_a, alu_b, alu_w;
  logic         alu_c, alu_zer, alu_neg;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_w;
  logic         rsp_zer, rsp_neg;

  int   n_checks = 0;
  int   n_errors = 0;
  rsp_t exp_q[$];

  alu_sequencer #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_cin   (cmd_cin),
    .alu_opc   (alu_opc),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .alu_w     (alu_w),
    .alu_zer   (alu_zer),
    .alu_neg   (alu_neg),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_w     (rsp_w),
    .rsp_zer   (rsp_zer),
    .rsp_neg   (rsp_neg)
  );

  always #5 clk = ~clk;

  // External ALU: 0 negate A, 1 increment A, 2 A+B+C, 3 A-B,
  // 4 AND, 5 OR, 6 XOR, 7 pass A.
  always_comb begin
    alu_w = '0;
    case (alu_opc)
      3'd0: alu_w = -alu_a;
      3'd1: alu_w = alu_a + 1'b1;
      3'd2: alu_w = alu_a + alu_b + {{(W-1){1'b0}}, alu_c};
      3'd3: alu_w = alu_a - alu_b;
      3'd4: alu_w = alu_a & alu_b;
      3'd5: alu_w = alu_a | alu_b;
      3'd6: alu_w = alu_a ^ alu_b;
      default: alu_w = alu_a;
    endcase
    alu_zer = (alu_w == '0);
    alu_neg = alu_w[W-1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Move to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_cin   = cin;
    cmd_valid = 1'b1;
  endtask

  // Wait for the accepting edge (bounded), queue the expected response, and
  // return how many mid-cycle samples saw cmd_ready low first.
  task automatic wait_accept(input rsp_t exp, output int waited);
    waited = 0;
    @(negedge clk);
    while (!cmd_ready) begin
      waited++;
      if (waited >= 20) begin
        check("accept_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    exp_q.push_back(exp);
    step();
    cmd_valid = 1'b0;
  endtask

  // Monitor: compares each consumed response against the queue head and
  // checks that a stalled response stays stable.
  initial begin
    logic         held;
    logic [W-1:0] held_w;
    logic         held_zer, held_neg;
    rsp_t         e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (rsp_valid && held) begin
        check("hold_rsp_w", rsp_w, held_w);
        check("hold_rsp_zer", rsp_zer, held_zer);
        check("hold_rsp_neg", rsp_neg, held_neg);
      end
      if (rsp_valid && exp_q.size() == 0) begin
        check("unexpected_rsp_valid", rsp_valid, 1'b0);
      end else if (rsp_valid && rsp_ready) begin
        e = exp_q.pop_front();
        check("rsp_w", rsp_w, e.w);
        check("rsp_zer", rsp_zer, e.zer);
        check("rsp_neg", rsp_neg, e.neg);
      end
      held     = rsp_valid && !rsp_ready;
      held_w   = rsp_w;
      held_zer = rsp_zer;
      held_neg = rsp_neg;
    end
  end

  // Directed stimulus.
  initial begin
    int           waited;
    int           budget;
    logic [W-1:0] b2b_a   [4] = '{16'h0010, 16'h7FFF, 16'hFFFF, 16'h1234};
    rsp_t         b2b_exp [4] = '{'{16'h0011, 1'b0, 1'b0}, '{16'h8000, 1'b0, 1'b1},
                                  '{16'h0000, 1'b1, 1'b0}, '{16'h1235, 1'b0, 1'b0}};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_cin = 1'b0; rsp_ready = 1'b1;

    // Reset values, before any clock edge.
    #2;
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_alu_opc", alu_opc, 3'b111);
    check("rst_rsp_w", rsp_w, 16'h0);
    repeat (2) step();
    rst_n = 1'b1;

    // ADD with carry: 5 + 3 + 1 = 9.
    drive_cmd(3'b010, 16'h0005, 16'h0003, 1'b1);
    wait_accept('{16'h0009, 1'b0, 1'b0}, waited);
    check("add_accept_wait", waited, 0);
    @(negedge clk);
    check("add_c1_opc", alu_opc, 3'b010);
    check("add_c1_a", alu_a, 16'h0005);
    check("add_c1_b", alu_b, 16'h0003);
    check("add_c1_c", alu_c, 1'b1);
    check("add_c1_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    check("add_c2_rsp_valid", rsp_valid, 1'b1);
    step();

    // SUB 3 - 5 = 0xFFFE via NEG then ADD.
    drive_cmd(3'd7, 16'h0003, 16'h0005, 1'b1);
    wait_accept('{16'hFFFE, 1'b0, 1'b1}, waited);
    @(negedge clk);
    check("sub_c1_opc", alu_opc, 3'b000);
    check("sub_c1_a", alu_a, 16'h0005);
    check("sub_c1_b", alu_b, 16'h0000);
    check("sub_c1_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    check("sub_c2_opc", alu_opc, 3'b010);
    check("sub_c2_a", alu_a, 16'h0003);
    check("sub_c2_b", alu_b, 16'hFFFB);
    check("sub_c2_c", alu_c, 1'b0);
    check("sub_c2_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk);
    check("sub_c3_rsp_valid", rsp_valid, 1'b1);
    check("sub_c3_alu_opc", alu_opc, 3'b111);
    step();

    // AND giving zero.
    drive_cmd(3'b100, 16'h00F0, 16'h0F00, 1'b0);
    wait_accept('{16'h0000, 1'b1, 1'b0}, waited);
    repeat (2) @(negedge clk);
    step();

    // SUB of equal operands.
    drive_cmd(3'd7, 16'h1234, 16'h1234, 1'b0);
    wait_accept('{16'h0000, 1'b1, 1'b0}, waited);
    repeat (3) @(negedge clk);
    step();

    // Back-pressure: response stalled 5 cycles with a second command pending.
    rsp_ready = 1'b0;
    drive_cmd(3'b110, 16'h00FF, 16'h0F0F, 1'b0);
    wait_accept('{16'h0FF0, 1'b0, 1'b0}, waited);
    drive_cmd(3'b101, 16'h1000, 16'h0001, 1'b0);
    @(negedge clk);
    check("bp_c1_cmd_ready", cmd_ready, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid, 1'b1);
      check("bp_rsp_w", rsp_w, 16'h0FF0);
      check("bp_cmd_ready", cmd_ready, 1'b0);
    end
    step();
    rsp_ready = 1'b1;
    wait_accept('{16'h1001, 1'b0, 1'b0}, waited);
    check("bp_second_accept_wait", waited, 1);
    repeat (2) @(negedge clk);
    step();

    // Reset pulsed during the ADD phase of a SUB.
    drive_cmd(3'd7, 16'h0009, 16'h0002, 1'b0);
    wait_accept('{16'h0007, 1'b0, 1'b0}, waited);
    @(negedge clk);
    check("rs_neg_opc", alu_opc, 3'b000);
    step();
    check("rs_in_add_opc", alu_opc, 3'b010);
    #2;
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    check("rs_cmd_ready", cmd_ready, 1'b1);
    check("rs_rsp_valid", rsp_valid, 1'b0);
    check("rs_alu_opc", alu_opc, 3'b111);
    check("rs_alu_a", alu_a, 16'h0);
    check("rs_alu_b", alu_b, 16'h0);
    check("rs_alu_c", alu_c, 1'b0);
    check("rs_rsp_w", rsp_w, 16'h0);
    check("rs_rsp_flags", {rsp_zer, rsp_neg}, 2'b00);
    drive_cmd(3'b001, 16'hFFFF, 16'h0000, 1'b0);
    step();
    @(negedge clk);
    check("rs_no_accept_opc", alu_opc, 3'b111);
    check("rs_no_accept_valid", rsp_valid, 1'b0);
    step();
    rst_n = 1'b1;
    wait_accept('{16'h0000, 1'b1, 1'b0}, waited);
    check("rs_first_accept_wait", waited, 0);
    @(negedge clk);
    check("rs_post_opc", alu_opc, 3'b001);
    check("rs_post_a", alu_a, 16'hFFFF);
    @(negedge clk);
    step();

    // Back-to-back increments: one accept every 3 cycles.
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_cmd(3'b001, b2b_a[i], 16'h0000, 1'b0);
      wait_accept(b2b_exp[i], waited);
      if (i > 0) check("b2b_spacing", waited, 2);
    end

    // Drain outstanding responses (bounded).
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check("queue_drained", exp_q.size(), 0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
